// File: rtl/regfile_dump_loader.sv
// Command engine that owns the register-file ports while busy: DUMP streams a register range out, LOAD writes a streamed range in.
// DUMP delivers one word per cycle under out_ready backpressure; LOAD writes land the cycle after each input accept.
module regfile_dump_loader #(
  parameter int NREGS  = 32,
  parameter int DWIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [$clog2(NREGS)-1:0]   cmd_start,
  input  logic [$clog2(NREGS+1)-1:0] cmd_count,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DWIDTH-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DWIDTH-1:0]          out_data,
  output logic [$clog2(NREGS)-1:0]   rf_rsel1,
  input  logic [DWIDTH-1:0]          rf_rdat1,
  output logic                       rf_wen,
  output logic [$clog2(NREGS)-1:0]   rf_wsel,
  output logic [DWIDTH-1:0]          rf_wdat,
  output logic                       busy,
  output logic                       done
);
  localparam int IW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  typedef enum logic [2:0] {IDLE, DUMP, LOAD, FLUSH, DONE} state_t;

  state_t        state, next_state;
  logic [IW-1:0] idx;
  logic [CW-1:0] remaining;
  logic          cmd_fire, in_fire, out_slot;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign in_fire  = in_valid && in_ready;
  // Output register can take a new word when empty or being drained this cycle.
  assign out_slot = (state == DUMP) && (!out_valid || out_ready);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_fire) next_state = (cmd_count == '0) ? DONE : (cmd_op ? LOAD : DUMP);
      DUMP:    if (out_slot && remaining == '0) next_state = DONE;
      LOAD:    if (in_fire && remaining == CW'(1)) next_state = FLUSH;
      FLUSH:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    rf_rsel1  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  cmd_ready = 1'b1;
      DUMP:  begin rf_rsel1 = idx; busy = 1'b1; end
      LOAD:  begin in_ready = (remaining != '0); busy = 1'b1; end
      FLUSH: busy = 1'b1;
      DONE:  begin done = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      rf_wen    <= 1'b0;
      rf_wsel   <= '0;
      rf_wdat   <= '0;
    end else begin
      rf_wen <= 1'b0;
      case (state)
        IDLE: if (cmd_fire) begin
          idx       <= cmd_start;
          remaining <= cmd_count;
        end
        DUMP: if (out_slot) begin
          if (remaining != '0) begin
            out_data  <= rf_rdat1;
            out_valid <= 1'b1;
            idx       <= (idx == IW'(NREGS - 1)) ? '0 : idx + 1'b1;
            remaining <= remaining - 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end
        LOAD: if (in_fire) begin
          rf_wen    <= 1'b1;
          rf_wsel   <= idx;
          rf_wdat   <= in_data;
          idx       <= (idx == IW'(NREGS - 1)) ? '0 : idx + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump_loader.sv
// Bench for regfile_dump_loader: directed table, corner sequences and random commands against an array model of the register file.
module tb_regfile_dump_loader;
  localparam int NREGS = 32;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [4:0]  cmd_start = '0;
  logic [5:0]  cmd_count = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  rf_rsel1, rf_wsel;
  logic [31:0] rf_rdat1, rf_wdat;
  logic        rf_wen, busy, done;

  regfile_dump_loader #(.NREGS(32), .DWIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_start(cmd_start), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rf_rsel1(rf_rsel1), .rf_rdat1(rf_rdat1),
    .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Register file the DUT talks to; the bench preloads it through its own port.
  logic [31:0] mem [NREGS];
  logic        tb_wen = 1'b0;
  logic [4:0]  tb_wsel = '0;
  logic [31:0] tb_wdat = '0;
  always @(posedge CLK) begin
    if (tb_wen)      mem[tb_wsel] <= tb_wdat;
    else if (rf_wen) mem[rf_wsel] <= rf_wdat;
  end
  assign rf_rdat1 = (rf_rsel1 == 5'd0) ? 32'h0 : mem[rf_rsel1];

  logic [31:0] ref_rf [NREGS];
  logic [31:0] exp_out[$], got_out[$], in_q[$], exp_dat[$], got_dat[$];
  int          exp_sel[$], got_sel[$];
  int          n_cmp = 0, n_err = 0;

  typedef struct {
    bit op;
    int start;
    int count;
    int dbase;
    int exp_lat;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input bit op, input int start, input int count, input int dbase,
                         input int stall0, input int gap, input bit rnd, input int abort_after,
                         output int lat);
    int k, nacc, viol, idx, nupd;
    bit drv, exp_wen, prev_stall;
    logic [31:0] prev_dat, w;
    exp_out.delete(); got_out.delete(); in_q.delete();
    exp_sel.delete(); exp_dat.delete(); got_sel.delete(); got_dat.delete();
    for (int i = 0; i < count; i++) begin
      idx = (start + i) % NREGS;
      if (!op) exp_out.push_back(idx == 0 ? 32'h0 : ref_rf[idx]);
      else begin
        w = (dbase != 0) ? 32'(dbase + i) : $urandom;
        in_q.push_back(w);
        exp_sel.push_back(idx);
        exp_dat.push_back(w);
      end
    end
    k = 0;
    while (!cmd_ready && k < 20) begin @(posedge CLK); #1; k++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_start = 5'(start); cmd_count = 6'(count);
    @(negedge CLK);
    @(posedge CLK); #1;
    // Keep offering junk commands while busy; none may be taken.
    cmd_op = ~op; cmd_start = 5'($urandom); cmd_count = 6'($urandom_range(1, 32));
    lat = -1; viol = 0; nacc = 0; exp_wen = 1'b0; prev_stall = 1'b0; prev_dat = '0;
    k = 1;
    while (k < 300 && lat < 0) begin
      drv = rnd ? 1'($urandom % 2) : (k > stall0 && ((k - stall0 - 1) % (gap + 1)) == 0);
      out_ready = !op && drv;
      in_valid  = op && drv && (in_q.size() > 0);
      in_data   = in_valid ? in_q[0] : $urandom;
      @(negedge CLK);
      if (!busy || cmd_ready) viol++;
      if (rf_wen !== exp_wen) viol++;
      if (!op && in_ready) viol++;
      if (op && out_valid) viol++;
      if (prev_stall && (!out_valid || out_data !== prev_dat)) viol++;
      if (rf_wen) begin got_sel.push_back(int'(rf_wsel)); got_dat.push_back(rf_wdat); end
      if (out_valid && out_ready) got_out.push_back(out_data);
      exp_wen = in_valid && in_ready;
      if (exp_wen) begin void'(in_q.pop_front()); nacc++; end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      if (done) lat = k - 1;
      @(posedge CLK); #1;
      k++;
      if (abort_after > 0 && nacc == abort_after) break;
    end
    cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("protocol_violations", 64'(viol), 64'd0);
    if (abort_after == 0) begin
      check("done_seen", 64'(lat >= 0), 64'd1);
      check("word_count", 64'(op ? got_sel.size() : got_out.size()), 64'(count));
      for (int i = 0; i < got_out.size() && i < exp_out.size(); i++)
        check("dump_word", 64'(got_out[i]), 64'(exp_out[i]));
      for (int i = 0; i < got_sel.size() && i < exp_sel.size(); i++) begin
        check("load_wsel", 64'(got_sel[i]), 64'(exp_sel[i]));
        check("load_wdat", 64'(got_dat[i]), 64'(exp_dat[i]));
      end
      @(negedge CLK);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
      check("done_single_pulse", 64'(done), 64'd0);
      @(posedge CLK); #1;
    end
    nupd = (abort_after > 0) ? nacc : count;
    if (op) for (int i = 0; i < nupd; i++) ref_rf[exp_sel[i]] = exp_dat[i];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tbl[0] = '{op:1'b1, start:30, count:4,  dbase:'hA, exp_lat:5};
    tbl[1] = '{op:1'b0, start:30, count:4,  dbase:0,   exp_lat:5};
    tbl[2] = '{op:1'b0, start:5,  count:0,  dbase:0,   exp_lat:0};
    tbl[3] = '{op:1'b1, start:9,  count:0,  dbase:0,   exp_lat:0};
    tbl[4] = '{op:1'b1, start:0,  count:32, dbase:0,   exp_lat:33};
    tbl[5] = '{op:1'b0, start:0,  count:32, dbase:0,   exp_lat:33};
    tbl[6] = '{op:1'b0, start:31, count:1,  dbase:0,   exp_lat:2};

    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    check("rst_rf_wsel", 64'(rf_wsel), 64'd0);
    check("rst_rf_wdat", 64'(rf_wdat), 64'd0);
    check("rst_rf_rsel1", 64'(rf_rsel1), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < NREGS; i++) begin
      tb_wen = 1'b1; tb_wsel = 5'(i);
      tb_wdat = (i >= 1 && i <= 3) ? 32'(i * 'h11) : $urandom;
      ref_rf[i] = tb_wdat;
      @(posedge CLK); #1;
    end
    tb_wen = 1'b0;

    run_cmd(1'b0, 1, 3, 0, 0, 0, 1'b0, 0, lat);
    check("dump123_latency", 64'(lat), 64'd4);
    check("dump123_w0", 64'(got_out[0]), 64'h11);
    check("dump123_w1", 64'(got_out[1]), 64'h22);
    check("dump123_w2", 64'(got_out[2]), 64'h33);

    run_cmd(1'b0, 0, 2, 0, 5, 0, 1'b0, 0, lat);
    check("dump_stall_latency", 64'(lat), 64'd7);
    check("dump_stall_r0", 64'(got_out[0]), 64'h0);

    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i].op, tbl[i].start, tbl[i].count, tbl[i].dbase, 0, 0, 1'b0, 0, lat);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      if (i == 1) check("wrap_r0_reads_zero", 64'(got_out[2]), 64'h0);
    end

    run_cmd(1'b1, 7, 2, 0, 0, 3, 1'b0, 0, lat);
    check("load_gap_latency", 64'(lat), 64'd6);

    run_cmd(1'b1, 10, 5, 'h50, 0, 0, 1'b0, 2, lat);
    RST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("abort_rf_wen", 64'(rf_wen), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    run_cmd(1'b0, 10, 5, 0, 0, 0, 1'b0, 0, lat);
    check("abort_kept_r10", 64'(got_out[0]), 64'h50);
    check("abort_kept_r11", 64'(got_out[1]), 64'h51);

    for (int t = 0; t < 25; t++)
      run_cmd(1'($urandom % 2), int'($urandom_range(0, 31)), int'($urandom_range(0, 32)),
              0, 0, 0, 1'b1, 0, lat);
    run_cmd(1'b0, 0, 32, 0, 0, 0, 1'b1, 0, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
